// File: rtl/keypad_debouncer_if.sv
// Keypad debouncer signal bundle: raw key lines in, debounced vector and strobes out.
// The debouncer takes the slave side of this bundle.
interface keypad_debouncer_if #(
    parameter int N_KEYS = 10
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] D_out;
    logic              key_valid;
    logic              key_release;
    logic              multi_key;

    modport master (
        output key_raw,
        input  D_out, key_valid, key_release, multi_key
    );

    modport slave (
        input  key_raw,
        output D_out, key_valid, key_release, multi_key
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Synchronises and debounces the raw keypad lines into a clean one-hot vector.
// It also generates single-cycle press/release strobes and locks out multi-key presses.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// IDLE         | no key accepted, D_out = 0
// PRESS_WAIT   | candidate pattern seen, counting identical samples
// PRESSED      | single key accepted, D_out holds it
// RELEASE_WAIT | accepted key disturbed, counting consecutive all-zero samples
// LOCKOUT      | multi-key pattern debounced, waiting for full release
module keypad_debouncer #(
    parameter int N_KEYS          = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    keypad_debouncer_if.slave  kif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT,
        LOCKOUT
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0][N_KEYS-1:0] sync_q;
    logic [N_KEYS-1:0] sync_key;
    logic [N_KEYS-1:0] cand, cand_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [N_KEYS-1:0] d_q, d_nx;
    logic              valid_q, valid_nx;
    logic              release_q, release_nx;
    logic              multi_q, multi_nx;
    logic              cand_onehot;

    assign sync_key    = sync_q[SYNC_STAGES-1];
    assign cand_onehot = (cand != '0) && ((cand & (cand - N_KEYS'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            d_q       <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], kif.key_raw};
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            d_q       <= d_nx;
            valid_q   <= valid_nx;
            release_q <= release_nx;
            multi_q   <= multi_nx;
        end
    end

    // Release/lockout counts hold the number of zero samples seen so far,
    // so leaving PRESSED on an all-zero sample already counts as one.
    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        cnt_nx     = cnt;
        d_nx       = d_q;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
        multi_nx   = multi_q;
        case (state)
            IDLE: begin
                d_nx     = '0;
                multi_nx = 1'b0;
                if (sync_key != '0) begin
                    state_nx = PRESS_WAIT;
                    cand_nx  = sync_key;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_key == '0) begin
                    state_nx = IDLE;
                end else if (sync_key != cand) begin
                    cand_nx = sync_key;
                    cnt_nx  = '0;
                end else if (cnt == CNT_ACCEPT) begin
                    cnt_nx = '0;
                    if (cand_onehot) begin
                        state_nx = PRESSED;
                        d_nx     = cand;
                        valid_nx = 1'b1;
                    end else begin
                        state_nx = LOCKOUT;
                        multi_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (sync_key != d_q) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = (sync_key == '0) ? CW'(1) : '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_key == d_q) begin
                    state_nx = PRESSED;
                end else if (sync_key == '0) begin
                    if (cnt == CNT_DONE) begin
                        state_nx   = IDLE;
                        d_nx       = '0;
                        release_nx = 1'b1;
                        cnt_nx     = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            LOCKOUT: begin
                if (sync_key == '0) begin
                    if (cnt == CNT_DONE) begin
                        state_nx = IDLE;
                        multi_nx = 1'b0;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign kif.D_out       = d_q;
    assign kif.key_valid   = valid_q;
    assign kif.key_release = release_q;
    assign kif.multi_key   = multi_q;
endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Vector e is driven before clock edge e and checked 1 time unit after it.
module tb_keypad_debouncer;
    localparam int NK = 10;
    localparam logic [NK-1:0] K2  = 10'b0000000100;
    localparam logic [NK-1:0] K3  = 10'b0000001000;
    localparam logic [NK-1:0] K4  = 10'b0000010000;
    localparam logic [NK-1:0] K5  = 10'b0000100000;
    localparam logic [NK-1:0] K7  = 10'b0010000000;
    localparam logic [NK-1:0] K09 = 10'b1000000001;

    typedef struct {
        int            tst;
        int            edge_n;
        logic [NK-1:0] raw;
        logic [NK-1:0] d;
        logic          v;
        logic          r;
        logic          m;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    keypad_debouncer_if #(.N_KEYS(NK)) kif();

    keypad_debouncer #(
        .N_KEYS(NK),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b want=%b", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NK-1:0] d, input logic v,
                           input logic r, input logic m);
        chk({tag, " D_out"}, kif.D_out, d);
        chk({tag, " key_valid"}, NK'(kif.key_valid), NK'(v));
        chk({tag, " key_release"}, NK'(kif.key_release), NK'(r));
        chk({tag, " multi_key"}, NK'(kif.multi_key), NK'(m));
    endtask

    function automatic void add(input int tst, input int e, input logic [NK-1:0] raw,
                                input logic [NK-1:0] d, input logic v, input logic r,
                                input logic m);
        vec_t x;
        x.tst = tst; x.edge_n = e; x.raw = raw; x.d = d; x.v = v; x.r = r; x.m = m;
        vecs.push_back(x);
    endfunction

    initial begin
        int rel_cnt;

        // Clean press/release of key 3.
        for (int e = 1; e <= 30; e++)
            add(2, e, (e < 20) ? K3 : '0, (e >= 6 && e < 25) ? K3 : '0,
                e == 6, e == 25, 1'b0);
        // Bounce on key 2 every two cycles, then a steady hold and release.
        for (int e = 1; e <= 40; e++) begin
            logic [NK-1:0] raw;
            if (e <= 20) raw = (((e - 1) / 2) % 2 == 0) ? K2 : '0;
            else if (e <= 30) raw = K2;
            else raw = '0;
            add(3, e, raw, (e >= 26 && e < 36) ? K2 : '0, e == 26, e == 36, 1'b0);
        end
        // Two keys together go to lockout and leave silently.
        for (int e = 1; e <= 20; e++)
            add(4, e, (e <= 10) ? K09 : '0, '0, 1'b0, 1'b0, e >= 6 && e < 16);
        // Roll-over: key 5 held, key 7 added, 5 released, then 7 released.
        for (int e = 1; e <= 26; e++) begin
            logic [NK-1:0] raw;
            if (e < 8) raw = K5;
            else if (e < 12) raw = K5 | K7;
            else if (e < 16) raw = K7;
            else raw = '0;
            add(5, e, raw, (e >= 6 && e < 21) ? K5 : '0, e == 6, e == 21, 1'b0);
        end

        // Reset with every key asserted.
        rst = 1'b1;
        kif.key_raw = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_all($sformatf("t1 rst%0d", i), '0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        kif.key_raw = '0;
        tick();
        chk_all("t1 post", '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();

        foreach (vecs[i]) begin
            kif.key_raw = vecs[i].raw;
            tick();
            chk_all($sformatf("t%0d e%0d", vecs[i].tst, vecs[i].edge_n),
                    vecs[i].d, vecs[i].v, vecs[i].r, vecs[i].m);
        end

        // Reset while a key is accepted and still held.
        kif.key_raw = K4;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 6) chk_all("t6 accept", K4, 1'b1, 1'b0, 1'b0);
        end
        chk_all("t6 held", K4, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("t6 rst", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("t6 re e%0d", e), (e >= 6) ? K4 : '0, e == 6, 1'b0, 1'b0);
        end
        kif.key_raw = '0;
        rel_cnt = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (kif.key_release === 1'b1) rel_cnt++;
            if (e == 6) chk_all("t6 release", '0, 1'b0, 1'b1, 1'b0);
        end
        chk("t6 release count", NK'(rel_cnt), NK'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
